// File: rtl/sd_sector_packer.sv
// sd_sector_packer
//   Packs a 16-bit sample stream into 256-word (512-byte) SD sectors for the
//   SD write controller. Two sector banks are used ping-pong: one fills from
//   the sample stream while the other is streamed out to the controller.
//
//   Optional feature macro: SD_PACK_SEQ_HEADER_EN
//     defined   -> word 0 of every sector is sector_cnt[15:0]; each bank
//                  carries 255 payload words in slots 1..255.
//     undefined -> all 256 words are payload.
//
//   Ports
//     sys_clk, sys_rst   clock, synchronous active-high reset
//     init_end           SD card ready; no new sector starts while low
//     in_valid/in_data   sample stream; a word moves when in_valid && in_ready
//     in_ready           fill bank has space and no pad is in progress
//     flush              pulse: pad the partial bank with PAD_WORD and close it
//     wr_busy, wr_req    controller status and per-word data request
//     wr_en              one-cycle sector write request
//     wr_addr            sector address, stable from wr_en until wr_busy falls
//     wr_data            current sector word (one-cycle prefetch after wr_req)
//     sector_cnt         sectors completed since reset
//     overflow           sticky: a word was offered while in_ready was low
//     idle               nothing buffered, drain FSM idle, controller not busy
//     dbg_state          one-hot drain FSM state
//
//   Handshake: the sample stream is valid/ready -- a word transfers on a
//   rising clock edge where in_valid and in_ready are both high; in_valid is
//   allowed while in_ready is low, but that word is dropped (and flagged).
module sd_sector_packer #(
    parameter int          WORDS_PER_SECTOR = 256,
    parameter logic [31:0] START_SECTOR     = 32'd0,
    parameter logic [15:0] PAD_WORD         = 16'hFFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        flush,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [31:0] sector_cnt,
    output logic        overflow,
    output logic        idle,
    output logic [4:0]  dbg_state
);

    localparam int               PW      = $clog2(WORDS_PER_SECTOR);
    localparam logic [PW:0]      PTR_END = (PW+1)'(WORDS_PER_SECTOR);
    localparam logic [PW-1:0]    RD_LAST = PW'(WORDS_PER_SECTOR - 1);
`ifdef SD_PACK_SEQ_HEADER_EN
    // Slot 0 is reserved for the sequence header, so filling starts at 1.
    localparam logic [PW:0]      FIRST_PTR = (PW+1)'(1);
`else
    localparam logic [PW:0]      FIRST_PTR = '0;
`endif

    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_START     = 5'b00010,
        S_WAIT_BUSY = 5'b00100,
        S_XFER      = 5'b01000,
        S_DONE      = 5'b10000
    } state_t;

    // Both banks live in one array; the bank select is the address MSB.
    logic [15:0]   r_mem [0:2*WORDS_PER_SECTOR-1];

    logic [1:0]    r_full;
    logic          r_fill_bank;
    logic [PW:0]   r_fill_ptr;
    logic          r_padding;
    logic          r_overflow;

    logic          r_drain_bank;
    logic [PW-1:0] r_rd_ptr;
    state_t        r_state;
    logic          r_wr_en;
    logic [31:0]   r_wr_addr;
    logic [15:0]   r_wr_data;
    logic [31:0]   r_sector_cnt;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_fill_we;
    logic [15:0]   w_fill_wdata;
    logic [PW:0]   w_fill_ptr_inc;
    logic          w_fill_last;
    logic [PW:0]   w_ptr_after;
    logic          w_flush_go;
    logic [PW:0]   w_fill_addr;
    logic [PW-1:0] w_rd_idx_next;
    logic [PW:0]   w_rd_addr;

    // ---------------------------------------------------------------- fill
    assign w_in_ready     = !r_full[r_fill_bank] && !r_padding;
    assign w_accept       = in_valid && w_in_ready;
    assign w_fill_we      = w_accept || r_padding;
    assign w_fill_wdata   = r_padding ? PAD_WORD : in_data;
    assign w_fill_ptr_inc = r_fill_ptr + (PW+1)'(1);
    assign w_fill_last    = w_fill_we && (w_fill_ptr_inc == PTR_END);
    assign w_fill_addr    = {r_fill_bank, r_fill_ptr[PW-1:0]};

    // A word accepted on the flush cycle is kept; padding then covers the rest.
    // If that word closes the bank there is nothing left to pad.
    assign w_ptr_after = w_accept ? w_fill_ptr_inc : r_fill_ptr;
    assign w_flush_go  = flush && !r_padding && !w_fill_last && (w_ptr_after > FIRST_PTR);

    always_ff @(posedge sys_clk) begin
        if (w_fill_we) begin
            r_mem[w_fill_addr] <= w_fill_wdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fill_ptr  <= FIRST_PTR;
            r_fill_bank <= 1'b0;
            r_padding   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_fill_we) begin
                if (w_fill_last) begin
                    r_fill_ptr  <= FIRST_PTR;
                    r_fill_bank <= ~r_fill_bank;
                    r_padding   <= 1'b0;
                end else begin
                    r_fill_ptr <= w_fill_ptr_inc;
                end
            end
            if (w_flush_go) begin
                r_padding <= 1'b1;
            end
        end
    end

    // Full flags: set by the fill side, cleared by the drain side. The two
    // never target the same bank in one cycle (fill only writes an empty
    // bank, DONE only releases a full one).
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_full <= 2'b00;
        end else begin
            if (r_state == S_DONE) begin
                r_full[r_drain_bank] <= 1'b0;
            end
            if (w_fill_last) begin
                r_full[r_fill_bank] <= 1'b1;
            end
        end
    end

    // --------------------------------------------------------------- drain
    assign w_rd_idx_next = r_rd_ptr + PW'(1);
    assign w_rd_addr     = {r_drain_bank, w_rd_idx_next};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_drain_bank <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= START_SECTOR;
            r_wr_data    <= 16'h0000;
            r_sector_cnt <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr_en <= 1'b0;
                    if (r_full[r_drain_bank] && init_end && !wr_busy) begin
                        r_rd_ptr <= '0;
`ifdef SD_PACK_SEQ_HEADER_EN
                        r_wr_data <= r_sector_cnt[15:0];
`else
                        r_wr_data <= r_mem[{r_drain_bank, {PW{1'b0}}}];
`endif
                        r_wr_en  <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (wr_busy) begin
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Past the last word the pointer parks, so wr_data keeps word 255.
                    if (wr_req && (r_rd_ptr != RD_LAST)) begin
                        r_rd_ptr  <= w_rd_idx_next;
                        r_wr_data <= r_mem[w_rd_addr];
                    end
                    if (!wr_busy) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_drain_bank <= ~r_drain_bank;
                    r_wr_addr    <= r_wr_addr + 32'd1;
                    r_sector_cnt <= r_sector_cnt + 32'd1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    assign in_ready   = w_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign sector_cnt = r_sector_cnt;
    assign overflow   = r_overflow;
    assign idle       = (r_full == 2'b00) && (r_state == S_IDLE) && !wr_busy &&
                        !r_padding && (r_fill_ptr == FIRST_PTR);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sd_sector_packer.sv
`timescale 1ns/1ps
module tb_sd_sector_packer;

    localparam int WPS = 256;
`ifdef SD_PACK_SEQ_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int          PAYLOAD = WPS - HDR;
    localparam logic [31:0] START   = 32'd0;
    localparam logic [15:0] PAD     = 16'hFFFF;

    logic        sys_clk, sys_rst, init_end, in_valid, flush, wr_busy, wr_req;
    logic [15:0] in_data;
    logic        in_ready, wr_en, overflow, idle;
    logic [31:0] wr_addr, sector_cnt;
    logic [15:0] wr_data;
    logic [4:0]  dbg_state;

    sd_sector_packer #(
        .WORDS_PER_SECTOR (WPS),
        .START_SECTOR     (START),
        .PAD_WORD         (PAD)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .init_end   (init_end),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .wr_busy    (wr_busy),
        .wr_req     (wr_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sector_cnt (sector_cnt),
        .overflow   (overflow),
        .idle       (idle),
        .dbg_state  (dbg_state)
    );

    // ---------------------------------------------------- clock / reset
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------- reference model
    // Sectors are formed from the accepted word sequence: every PAYLOAD
    // words close a sector (prefixed by its index when headers are on);
    // a flush tops the current sector up with PAD.
    logic [15:0] exp_q[$];
    int ref_cur     = 0;
    int ref_sec_idx = 0;
    int sec_started = 0;
    bit exp_ovf     = 0;

    task automatic ref_push(input logic [15:0] w);
        if (ref_cur == 0 && HDR == 1) exp_q.push_back(ref_sec_idx[15:0]);
        exp_q.push_back(w);
        ref_cur++;
        if (ref_cur == PAYLOAD) begin
            ref_cur = 0;
            ref_sec_idx++;
        end
    endtask

    task automatic ref_flush();
        while (ref_cur != 0) ref_push(PAD);
    endtask

    function automatic int partial_len();
        return (ref_cur > 0) ? ref_cur + HDR : 0;
    endfunction

    // ----------------------------------------- SD controller model / scoreboard
    int          m_state = 0, m_cnt = 0, m_n = 0, m_hold_cfg = 0;
    bit          m_stall = 0, m_reset = 0, m_rand_req = 0, m_rand_hold = 0;
    logic [15:0] m_last;

    initial begin
        logic [15:0] e;
        wr_busy = 1'b0;
        wr_req  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (m_reset) begin
                wr_busy = 1'b0;
                wr_req  = 1'b0;
                m_state = 0;
            end else begin
                case (m_state)
                    0: begin
                        wr_req = 1'b0;
                        if (wr_en) begin
                            check("wr_addr", wr_addr, START + 32'(sec_started));
                            sec_started++;
                            m_state = 1;
                        end
                    end
                    1: begin
                        check("wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
                        m_state = 2;
                    end
                    2: if (!m_stall) begin
                        wr_busy = 1'b1;
                        m_cnt   = m_rand_hold ? int'($urandom_range(0, 20)) : m_hold_cfg;
                        m_state = 3;
                    end
                    3: begin
                        if (m_cnt > 0) m_cnt--;
                        else begin
                            m_n     = 0;
                            m_state = 4;
                        end
                    end
                    4: begin
                        if (m_n == WPS) begin
                            wr_req  = 1'b1;   // one request too many
                            m_state = 5;
                        end else if (!m_rand_req || $urandom_range(0, 2) != 0) begin
                            wr_req = 1'b1;
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL wr_data_unexpected actual=%0h expected=none", wr_data);
                            end else begin
                                e = exp_q.pop_front();
                                if (wr_data !== e) begin
                                    errors++;
                                    $display("FAIL wr_data word=%0d actual=%0h expected=%0h", m_n, wr_data, e);
                                end
                            end
                            m_last = wr_data;
                            m_n++;
                        end else begin
                            wr_req = 1'b0;
                        end
                    end
                    5: begin
                        wr_req = 1'b0;
                        check("wr_data_hold_last", {16'd0, wr_data}, {16'd0, m_last});
                        wr_busy = 1'b0;
                        m_state = 0;
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    // ------------------------------------------------------ driver tasks
    task automatic do_reset(input bit chk);
        @(negedge sys_clk);
        sys_rst = 1'b1; m_reset = 1'b1;
        wr_busy = 1'b0; wr_req = 1'b0; in_valid = 1'b0; flush = 1'b0;
        @(negedge sys_clk);
        if (chk) begin
            check("rst_wr_en",      {31'd0, wr_en},    32'd0);
            check("rst_wr_addr",    wr_addr,           START);
            check("rst_wr_data",    {16'd0, wr_data},  32'd0);
            check("rst_sector_cnt", sector_cnt,        32'd0);
            check("rst_overflow",   {31'd0, overflow}, 32'd0);
            check("rst_in_ready",   {31'd0, in_ready}, 32'd1);
            check("rst_idle",       {31'd0, idle},     32'd1);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0; m_reset = 1'b0;
        exp_q.delete();
        ref_cur = 0; ref_sec_idx = 0; sec_started = 0; exp_ovf = 0;
    endtask

    // Starts and ends on a falling edge; in_ready is read before the rising edge.
    task automatic feed(input int n, input bit seq, output int acc, output int first_ref);
        logic [15:0] d;
        acc = 0; first_ref = -1;
        for (int i = 0; i < n; i++) begin
            d = seq ? i[15:0] : 16'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready) begin
                ref_push(d);
                acc++;
            end else begin
                if (first_ref < 0) first_ref = i;
                exp_ovf = 1;
            end
            @(negedge sys_clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sectors(input string name);
        int t = 0;
        while (!(exp_q.size() == partial_len() && m_state == 0 && sec_started == ref_sec_idx)
               && t < 20000) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 20000) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=%0d_words_left expected=%0d", name, exp_q.size(), partial_len());
        end
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic finish_partial(input string name);
        if (ref_cur > 0) begin
            flush = 1'b1;
            ref_flush();
            @(negedge sys_clk);
            flush = 1'b0;
        end
        wait_sectors(name);
        check({name, "_all_drained"}, exp_q.size(), 32'd0);
    endtask

    // ---------------------------------------------------------- vectors
    typedef struct {
        int n_words;
        bit seq_data;
        bit stall;
        int hold;
        bit do_flush;
        int exp_acc;
        int exp_first_ref;
        bit exp_ready_after;
        int exp_sectors;
        bit exp_ovf;
    } vec_t;

    function automatic int cap_acc(input int n);
        return (n < 2 * PAYLOAD) ? n : 2 * PAYLOAD;
    endfunction

    vec_t vecs[4];

    initial begin
        int acc, first_ref, t;
        logic [15:0] d;
        bit v, f;

        // single sector 0..255
        vecs[0] = '{n_words: 256, seq_data: 1'b1, stall: 1'b0, hold: 3, do_flush: 1'b0,
                    exp_acc: cap_acc(256), exp_first_ref: -1, exp_ready_after: 1'b1,
                    exp_sectors: 256 / PAYLOAD, exp_ovf: 1'b0};
        // 512 words while the first sector is held busy for 2000 cycles
        vecs[1] = '{n_words: 512, seq_data: 1'b0, stall: 1'b0, hold: 2000, do_flush: 1'b0,
                    exp_acc: cap_acc(512), exp_first_ref: (512 > 2 * PAYLOAD) ? 2 * PAYLOAD : -1,
                    exp_ready_after: 1'b0, exp_sectors: 2, exp_ovf: (512 > 2 * PAYLOAD)};
        // controller stalled, 600 words offered
        vecs[2] = '{n_words: 600, seq_data: 1'b0, stall: 1'b1, hold: 0, do_flush: 1'b0,
                    exp_acc: cap_acc(600), exp_first_ref: 2 * PAYLOAD, exp_ready_after: 1'b0,
                    exp_sectors: 2, exp_ovf: 1'b1};
        // 10 words then flush
        vecs[3] = '{n_words: 10, seq_data: 1'b1, stall: 1'b0, hold: 5, do_flush: 1'b1,
                    exp_acc: 10, exp_first_ref: -1, exp_ready_after: 1'b1,
                    exp_sectors: 1, exp_ovf: 1'b0};

        sys_rst = 1'b1; init_end = 1'b1; in_valid = 1'b0; in_data = 16'h0; flush = 1'b0;
        repeat (3) @(negedge sys_clk);
        do_reset(1'b1);

        for (int r = 0; r < 4; r++) begin
            do_reset(1'b0);
            m_hold_cfg = vecs[r].hold; m_stall = vecs[r].stall;
            m_rand_req = 0; m_rand_hold = 0;
            feed(vecs[r].n_words, vecs[r].seq_data, acc, first_ref);
            check($sformatf("v%0d_accepted", r), acc, vecs[r].exp_acc);
            check($sformatf("v%0d_first_refused", r), first_ref, vecs[r].exp_first_ref);
            check($sformatf("v%0d_in_ready_after", r), {31'd0, in_ready}, {31'd0, vecs[r].exp_ready_after});
            if (vecs[r].do_flush) begin
                flush = 1'b1;
                ref_flush();
                @(negedge sys_clk);
                flush = 1'b0;
                check($sformatf("v%0d_pad_block_start", r), {31'd0, in_ready}, 32'd0);
                repeat (100) @(negedge sys_clk);
                check($sformatf("v%0d_pad_block_mid", r), {31'd0, in_ready}, 32'd0);
            end
            m_stall = 0;
            wait_sectors($sformatf("v%0d", r));
            check($sformatf("v%0d_sector_cnt", r), sector_cnt, 32'(vecs[r].exp_sectors));
            check($sformatf("v%0d_overflow", r), {31'd0, overflow}, {31'd0, vecs[r].exp_ovf});
            finish_partial($sformatf("v%0d_tail", r));
            check($sformatf("v%0d_idle", r), {31'd0, idle}, 32'd1);
        end

        // reset in the middle of a transfer
        do_reset(1'b0);
        m_hold_cfg = 0;
        feed(256, 1'b1, acc, first_ref);
        t = 0;
        while (!(m_state == 4 && m_n >= 100) && t < 5000) begin
            @(negedge sys_clk);
            t++;
        end
        check("midxfer_reached", {31'd0, (t < 5000)}, 32'd1);
        do_reset(1'b1);
        feed(256, 1'b0, acc, first_ref);
        finish_partial("after_reset");
        check("after_reset_sector_cnt", sector_cnt, 32'(ref_sec_idx));

        // init_end low holds off new sectors
        do_reset(1'b0);
        init_end = 1'b0;
        feed(256, 1'b0, acc, first_ref);
        repeat (50) @(negedge sys_clk);
        check("no_start_wr_en", sec_started, 32'd0);
        check("no_start_cnt", sector_cnt, 32'd0);
        init_end = 1'b1;
        finish_partial("init_resume");
        check("init_resume_cnt", sector_cnt, 32'(ref_sec_idx));

        // randomized stream, random flushes, random controller timing
        do_reset(1'b0);
        m_rand_req = 1; m_rand_hold = 1;
        for (int c = 0; c < 6000; c++) begin
            v = ($urandom_range(0, 99) < 70);
            f = ($urandom_range(0, 299) == 0);
            d = 16'($urandom);
            in_valid = v; in_data = d; flush = f;
            if (v) begin
                if (in_ready) ref_push(d);
                else exp_ovf = 1;
            end
            if (f) ref_flush();
            @(negedge sys_clk);
        end
        in_valid = 1'b0; flush = 1'b0;
        finish_partial("rand");
        check("rand_sector_cnt", sector_cnt, 32'(ref_sec_idx));
        check("rand_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check("rand_idle", {31'd0, idle}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
